ro_tdc_sequencer: RTL and testbench
===================================

RO_TDC_SEQUENCER -- requirements
Module: ro_tdc_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16, ring-oscillator settle cycles after enable and select.
REQ-002 SHALL have parameter CAP_LAT, default 2, cycles from gate close to a stable ro_count.
REQ-003 SHALL have port clk  in  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins a sweep.
REQ-006 SHALL have port abort  in  1  one-cycle pulse that ends any sweep.
REQ-007 SHALL have port chan_mask  in  4  channels to measure; bit i enables RO channel i.
REQ-008 SHALL have port gate_sel  in  2  gate length select: 0=64, 1=256, 2=1024, 3=4096 cycles.
REQ-009 SHALL have port cont  in  1  continuous mode: repeat the sweep until abort.
REQ-010 SHALL have port ro_count  in  16  edge count from the TDC counter, synchronous to clk.
REQ-011 SHALL have port ro_ovf  in  1  TDC counter overflow flag.
REQ-012 SHALL have port ro_sel  out  2  oscillator mux select to the datapath.
REQ-013 SHALL have port ro_en  out  1  oscillator enable.
REQ-014 SHALL have port cnt_clr  out  1  one-cycle synchronous clear of the TDC counter.
REQ-015 SHALL have port cnt_gate  out  1  counter gate; counting is allowed while high.
REQ-016 SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-017 SHALL have port done  out  1  one-cycle pulse at the end of each sweep.
REQ-018 SHALL have port rd_chan  in  2  readback channel.
REQ-019 SHALL have port rd_hi  in  1  readback byte select: 1=upper byte, 0=lower byte.
REQ-020 SHALL have port rd_data  out  8  selected result byte, combinational from the result registers.
REQ-021 SHALL have port valid  out  4  per-channel result-valid flags.
REQ-022 SHALL have port ovf  out  4  per-channel overflow flags.

Function
REQ-023 SHALL implement states IDLE, SELECT, SETTLE, GATE, CAPTURE and NEXT.
REQ-024 In IDLE, start SHALL latch chan_mask, gate_sel and cont into shadow registers and go to NEXT; start while busy SHALL be ignored.
REQ-025 NEXT SHALL pick the lowest-numbered unvisited channel in the shadow mask and go to SELECT; with none left it SHALL pulse done and then go to IDLE, or restart the sweep from channel 0 if shadow cont=1.
REQ-026 SELECT (1 cycle) SHALL drive ro_sel, assert cnt_clr, set ro_en=1, clear valid[ch] and go to SETTLE.
REQ-027 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to GATE.
REQ-028 GATE SHALL hold cnt_gate=1 for exactly the selected gate length, then go to CAPTURE.
REQ-029 CAPTURE SHALL wait CAP_LAT cycles; on the last of them it SHALL store ro_count into result[ch], store ro_ovf into ovf[ch], set valid[ch], drop ro_en, mark ch visited and go to NEXT.
REQ-030 A shadow mask of 0 SHALL produce done on the cycle after start and leave all results untouched.
REQ-031 ro_sel SHALL hold its value outside SELECT; ro_en SHALL be 0 in IDLE and NEXT.
REQ-032 The gate counter SHALL be 13 bits wide and SHALL count down from the gate length minus 1; no wrap is permitted.
REQ-033 Abort SHALL take priority over all other events: the next state is IDLE, ro_en=cnt_gate=0, done is not pulsed, and the current channel's valid stays 0.
REQ-034 When start and abort arrive in the same cycle in IDLE, the block SHALL stay IDLE.
REQ-035 Results SHALL be readable at any time; rd_data for a channel with valid=0 SHALL show the previous (stale) value.

Reset
REQ-036 rst_n=0 SHALL force IDLE asynchronously and clear every register: results=0, valid=0, ovf=0, ro_sel=0, ro_en=0, cnt_clr=0, cnt_gate=0, busy=0, done=0.
REQ-037 Reset during a sweep SHALL leave no pending done pulse and no pending capture.

Structure
REQ-038 A shared package ro_tdc_pkg SHALL hold the state enum, the gate-length lookup table and the widths (CNT_W=16, NCH=4).
REQ-039 The result bank and readback mux SHALL be one sub-module, ro_tdc_resbank (4x16-bit registers with valid and ovf flags).

Verification
REQ-040 mask=4'b0101, gate_sel=0, ro_count model = 3 per gate cycle -> channels 0 then 2 measured, result0=result2=192, valid=0101, done once, total latency 2*(1+16+64+2)+2 cycles.
REQ-041 mask=0 -> done pulse 1 cycle after start, busy high for exactly 1 cycle, valid unchanged.
REQ-042 Abort injected during GATE of channel 1 -> IDLE next cycle, ro_en=0, valid[1]=0, no done pulse.
REQ-043 cont=1, mask=4'b1000 -> repeated channel-3 measurements with done after each; start during the run is ignored; abort stops the loop.
REQ-044 ro_ovf=1 at capture with ro_count=16'hFFFF -> ovf[ch]=1; rd_hi=1 reads 8'hFF, rd_hi=0 reads 8'hFF.
REQ-045 rst_n asserted mid-SETTLE -> all outputs 0 immediately; after release, a new start runs a clean sweep.

Source files
------------

// File: rtl/ro_tdc_pkg.sv
// Shared types and constants for the ring-oscillator TDC sequencer.
// Holds the state encoding, the gate-length table, the widths and small helpers.
package ro_tdc_pkg;
    localparam int CNT_W  = 16;
    localparam int NCH    = 4;
    localparam int CH_W   = 2;
    localparam int GCNT_W = 13;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        GATE,
        CAPTURE,
        NEXT
    } state_t;

    localparam logic [GCNT_W-1:0] GATE_LEN [4] = '{13'd64, 13'd256, 13'd1024, 13'd4096};

    function automatic logic [GCNT_W-1:0] gate_load(input logic [1:0] sel);
        return GATE_LEN[sel] - GCNT_W'(1);
    endfunction

    function automatic logic [CH_W-1:0] lowest_ch(input logic [NCH-1:0] m);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/ro_tdc_resbank.sv
// Per-channel result registers with valid/ovf flags and a combinational byte readback.
// Writes land one cycle after wr; readback has no latency and no flow control.
module ro_tdc_resbank
    import ro_tdc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CH_W-1:0]  clr_ch,
    input  logic             wr,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             wr_ovf,
    input  logic [CH_W-1:0]  rd_chan,
    input  logic             rd_hi,
    output logic [7:0]       rd_data,
    output logic [NCH-1:0]   valid,
    output logic [NCH-1:0]   ovf
);
    logic [CNT_W-1:0] res [NCH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) res[i] <= '0;
            valid <= '0;
            ovf   <= '0;
        end else begin
            if (clr) valid[clr_ch] <= 1'b0;
            if (wr) begin
                res[wr_ch]   <= wr_data;
                ovf[wr_ch]   <= wr_ovf;
                valid[wr_ch] <= 1'b1;
            end
        end
    end

    // Stale data stays readable while valid is low; only the flag tells it apart.
    assign rd_data = rd_hi ? res[rd_chan][15:8] : res[rd_chan][7:0];
endmodule

// File: rtl/ro_tdc_sequencer.sv
// Sweeps the masked RO channels: select, settle, gate the TDC counter, capture the count.
// Per channel 1+SETTLE_CYC+gate+CAP_LAT cycles plus one NEXT cycle; abort wins over everything.
module ro_tdc_sequencer
    import ro_tdc_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int CAP_LAT    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [NCH-1:0]   chan_mask,
    input  logic [1:0]       gate_sel,
    input  logic             cont,
    input  logic [CNT_W-1:0] ro_count,
    input  logic             ro_ovf,
    output logic [CH_W-1:0]  ro_sel,
    output logic             ro_en,
    output logic             cnt_clr,
    output logic             cnt_gate,
    output logic             busy,
    output logic             done,
    input  logic [CH_W-1:0]  rd_chan,
    input  logic             rd_hi,
    output logic [7:0]       rd_data,
    output logic [NCH-1:0]   valid,
    output logic [NCH-1:0]   ovf
);
    state_t              state, state_n;
    logic [NCH-1:0]      sh_mask, visited, visited_n, rem;
    logic [1:0]          sh_gate;
    logic                sh_cont, load_sh;
    logic [CH_W-1:0]     sel_q, sel_n;
    logic [GCNT_W-1:0]   tmr, tmr_n;
    logic                cap_wr, vld_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh_mask <= '0;
            sh_gate <= '0;
            sh_cont <= 1'b0;
            visited <= '0;
            sel_q   <= '0;
            tmr     <= '0;
        end else begin
            state   <= state_n;
            visited <= visited_n;
            sel_q   <= sel_n;
            tmr     <= tmr_n;
            if (load_sh) begin
                sh_mask <= chan_mask;
                sh_gate <= gate_sel;
                sh_cont <= cont;
            end
        end
    end

    assign rem = sh_mask & ~visited;

    always_comb begin
        state_n   = state;
        visited_n = visited;
        sel_n     = sel_q;
        tmr_n     = tmr;
        load_sh   = 1'b0;
        done      = 1'b0;
        cap_wr    = 1'b0;
        vld_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_sh   = 1'b1;
                    visited_n = '0;
                    state_n   = NEXT;
                end
            end
            NEXT: begin
                if (rem != '0) begin
                    sel_n   = lowest_ch(rem);
                    state_n = SELECT;
                end else begin
                    done      = 1'b1;
                    visited_n = '0;
                    // Continuous mode restarts straight into the first channel so every
                    // sweep, first or repeated, has the same length.
                    if (sh_cont && sh_mask != '0) begin
                        sel_n   = lowest_ch(sh_mask);
                        state_n = SELECT;
                    end else if (sh_cont) begin
                        state_n = NEXT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            SELECT: begin
                vld_clr = 1'b1;
                tmr_n   = GCNT_W'(SETTLE_CYC - 1);
                state_n = SETTLE;
            end
            SETTLE: begin
                if (tmr == '0) begin
                    tmr_n   = gate_load(sh_gate);
                    state_n = GATE;
                end else begin
                    tmr_n = tmr - GCNT_W'(1);
                end
            end
            GATE: begin
                if (tmr == '0) begin
                    tmr_n   = GCNT_W'(CAP_LAT - 1);
                    state_n = CAPTURE;
                end else begin
                    tmr_n = tmr - GCNT_W'(1);
                end
            end
            CAPTURE: begin
                if (tmr == '0) begin
                    cap_wr    = 1'b1;
                    visited_n = visited | (NCH'(1) << sel_q);
                    state_n   = NEXT;
                end else begin
                    tmr_n = tmr - GCNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (abort) begin
            state_n   = IDLE;
            load_sh   = 1'b0;
            done      = 1'b0;
            cap_wr    = 1'b0;
            visited_n = visited;
            sel_n     = sel_q;
        end
    end

    assign ro_sel   = sel_q;
    assign busy     = (state != IDLE);
    assign ro_en    = (state == SELECT) || (state == SETTLE) || (state == GATE) || (state == CAPTURE);
    assign cnt_clr  = (state == SELECT);
    assign cnt_gate = (state == GATE);

    ro_tdc_resbank u_resbank (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (vld_clr),
        .clr_ch  (sel_q),
        .wr      (cap_wr),
        .wr_ch   (sel_q),
        .wr_data (ro_count),
        .wr_ovf  (ro_ovf),
        .rd_chan (rd_chan),
        .rd_hi   (rd_hi),
        .rd_data (rd_data),
        .valid   (valid),
        .ovf     (ovf)
    );
endmodule

// File: tb/tb_ro_tdc_sequencer.sv
// Directed and randomized sweeps of ro_tdc_sequencer against a saturating TDC counter
// and a per-sweep result model (counts = gate length x per-channel rate, clipped at 16 bits).
module tb_ro_tdc_sequencer;
    localparam int SETTLE = 16;
    localparam int CAPL   = 2;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, cont = 1'b0, rd_hi = 1'b0;
    logic [3:0]  chan_mask = '0;
    logic [1:0]  gate_sel = '0, rd_chan = '0, ro_sel;
    logic [15:0] ro_count;
    logic        ro_ovf, ro_en, cnt_clr, cnt_gate, busy, done;
    logic [7:0]  rd_data;
    logic [3:0]  valid, ovf;

    int errors = 0, checks = 0, done_cnt = 0, cyc = 0;
    int unsigned inc [4];
    logic [15:0] tcnt = '0;
    logic        tovf = 1'b0;

    logic [15:0] exp_res [4];
    logic [3:0]  exp_vld = '0, exp_ovf = '0;

    always #5 clk = ~clk;

    ro_tdc_sequencer #(.SETTLE_CYC(SETTLE), .CAP_LAT(CAPL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .chan_mask(chan_mask),
        .gate_sel(gate_sel), .cont(cont), .ro_count(ro_count), .ro_ovf(ro_ovf),
        .ro_sel(ro_sel), .ro_en(ro_en), .cnt_clr(cnt_clr), .cnt_gate(cnt_gate),
        .busy(busy), .done(done), .rd_chan(rd_chan), .rd_hi(rd_hi), .rd_data(rd_data),
        .valid(valid), .ovf(ovf)
    );

    // TDC counter stand-in: inc[ro_sel] edges per gated cycle, saturating with overflow.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (cnt_clr) begin
            tcnt <= '0;
            tovf <= 1'b0;
        end else if (cnt_gate) begin
            if (32'(tcnt) + inc[ro_sel] > 32'd65535) begin
                tcnt <= 16'hFFFF;
                tovf <= 1'b1;
            end else begin
                tcnt <= tcnt + 16'(inc[ro_sel]);
            end
        end
    end
    assign ro_count = tcnt;
    assign ro_ovf   = tovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bank(input string tag);
        for (int ch = 0; ch < 4; ch++) begin
            rd_chan = 2'(ch);
            rd_hi = 1'b0;
            #1;
            check($sformatf("%s_ch%0d_lo", tag, ch), 32'(rd_data), 32'(exp_res[ch][7:0]));
            rd_hi = 1'b1;
            #1;
            check($sformatf("%s_ch%0d_hi", tag, ch), 32'(rd_data), 32'(exp_res[ch][15:8]));
        end
        check({tag, "_valid"}, 32'(valid), 32'(exp_vld));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    endtask

    // Expected sweep outcome from the channel rates; returns the start-to-done latency.
    task automatic model_sweep(input logic [3:0] m, input logic [1:0] gs, output int lat);
        longint gl, p;
        gl  = 64 << (2 * int'(gs));
        lat = 0;
        for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) begin
                p = gl * longint'(inc[ch]);
                exp_res[ch] = (p > 65535) ? 16'hFFFF : 16'(p);
                exp_ovf[ch] = (p > 65535);
                exp_vld[ch] = 1'b1;
                lat += 1 + SETTLE + int'(gl) + CAPL + 1;
            end
        end
    endtask

    task automatic do_start(input logic [3:0] m, input logic [1:0] gs, input logic c, output int t0);
        @(negedge clk);
        chan_mask = m;
        gate_sel  = gs;
        cont      = c;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        chan_mask = 4'($urandom);
        gate_sel  = 2'($urandom);
        cont      = 1'b0;
        t0        = cyc;
    endtask

    task automatic wait_done(input int limit, output int t);
        int w;
        w = 0;
        @(negedge clk);
        while (!done && w < limit) begin
            @(negedge clk);
            w++;
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL wait_done: no done within %0d cycles", limit);
        end
        t = cyc;
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    initial begin
        int t0, t1, t2, t3, lat, d0, nb, w;
        logic [3:0] m;
        logic [1:0] gs;

        for (int i = 0; i < 4; i++) begin
            inc[i] = 3;
            exp_res[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_outs", {28'd0, ro_en, cnt_clr, cnt_gate, 1'b0}, 0);
        check("rst_ro_sel", 32'(ro_sel), 0);
        check_bank("rst");
        rst_n = 1'b1;

        // Channels 0 and 2, shortest gate, 3 edges per gated cycle
        d0 = done_cnt;
        do_start(4'b0101, 2'd0, 1'b0, t0);
        wait_done(2000, t1);
        model_sweep(4'b0101, 2'd0, lat);
        check("m0101_latency", 32'(t1 - t0), 32'(lat));
        @(negedge clk);
        check("m0101_busy_after", 32'(busy), 0);
        check("m0101_ro_en_after", 32'(ro_en), 0);
        check("m0101_done_count", 32'(done_cnt - d0), 1);
        check_bank("m0101");

        // Empty mask
        d0 = done_cnt;
        do_start(4'b0000, 2'd2, 1'b0, t0);
        @(negedge clk);
        check("m0_done_next_cycle", 32'(done), 1);
        nb = int'(busy);
        repeat (3) begin
            @(negedge clk);
            nb += int'(busy);
        end
        check("m0_busy_cycles", 32'(nb), 1);
        check("m0_done_count", 32'(done_cnt - d0), 1);
        check_bank("m0");

        // Randomized sweeps
        for (int r = 0; r < 5; r++) begin
            m  = 4'($urandom_range(0, 15));
            gs = 2'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) inc[i] = $urandom_range(1, 400);
            d0 = done_cnt;
            do_start(m, gs, 1'b0, t0);
            wait_done(5000, t1);
            model_sweep(m, gs, lat);
            check($sformatf("rnd%0d_latency", r), 32'(t1 - t0), 32'(lat));
            @(negedge clk);
            check($sformatf("rnd%0d_done_count", r), 32'(done_cnt - d0), 1);
            check_bank($sformatf("rnd%0d", r));
        end

        // Abort during the gate of channel 1
        d0 = done_cnt;
        do_start(4'b0010, 2'd1, 1'b0, t0);
        w = 0;
        while (!(cnt_gate && ro_sel == 2'd1) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("abort_reached_gate", 32'(cnt_gate && ro_sel == 2'd1), 1);
        repeat (10) @(negedge clk);
        pulse_abort();
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_ro_en", 32'(ro_en), 0);
        check("abort_cnt_gate", 32'(cnt_gate), 0);
        exp_vld[1] = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 0);
        check_bank("abort");

        // Start and abort together while idle
        @(negedge clk);
        chan_mask = 4'b1111;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle_busy", 32'(busy), 0);

        // Continuous mode on channel 3; a start mid-run must be ignored
        inc[3] = 5;
        d0 = done_cnt;
        do_start(4'b1000, 2'd0, 1'b1, t0);
        wait_done(300, t1);
        model_sweep(4'b1000, 2'd0, lat);
        check("cont_first_latency", 32'(t1 - t0), 32'(lat));
        repeat (20) @(negedge clk);
        do_start(4'b0001, 2'd0, 1'b0, t0);
        wait_done(300, t2);
        check("cont_period_2", 32'(t2 - t1), 32'(lat));
        wait_done(300, t3);
        check("cont_period_3", 32'(t3 - t2), 32'(lat));
        repeat (10) @(negedge clk);
        pulse_abort();
        @(negedge clk);
        check("cont_abort_busy", 32'(busy), 0);
        check("cont_done_count", 32'(done_cnt - d0), 3);
        exp_vld[3] = 1'b0;
        check_bank("cont");

        // Overflow at capture
        inc[0] = 16;
        do_start(4'b0001, 2'd3, 1'b0, t0);
        wait_done(6000, t1);
        model_sweep(4'b0001, 2'd3, lat);
        check("ovf_latency", 32'(t1 - t0), 32'(lat));
        @(negedge clk);
        check_bank("ovf");

        // Reset in the middle of SETTLE
        do_start(4'b0100, 2'd0, 1'b0, t0);
        w = 0;
        while (!(ro_en && !cnt_clr && !cnt_gate) && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
        check("rstmid_in_settle", {29'd0, ro_en, cnt_clr, cnt_gate}, 32'b100);
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_outs", {28'd0, ro_en, cnt_clr, cnt_gate, done}, 0);
        check("rstmid_ro_sel", 32'(ro_sel), 0);
        for (int i = 0; i < 4; i++) exp_res[i] = '0;
        exp_vld = '0;
        exp_ovf = '0;
        check_bank("rstmid");
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rstmid_no_pending_done", 32'(done_cnt - d0), 0);
        check("rstmid_valid_still_0", 32'(valid), 0);
        inc[2] = 7;
        do_start(4'b0100, 2'd0, 1'b0, t0);
        wait_done(300, t1);
        model_sweep(4'b0100, 2'd0, lat);
        check("rstmid_clean_latency", 32'(t1 - t0), 32'(lat));
        @(negedge clk);
        check_bank("rstmid_clean");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule
